// File: rtl/tpu_pkg.sv
// Shared constants and state encoding for the 2x2 TPU datapath.
// The control unit and the writeback stage both size themselves from these.
package tpu_pkg;

  localparam int ACC_W         = 16;
  localparam int NUM_RES       = 4;
  localparam int BYTES_PER_RES = ACC_W / 8;
  localparam int NUM_BEATS     = NUM_RES * BYTES_PER_RES;
  localparam int BEAT_W        = $clog2(NUM_BEATS);

  typedef enum logic {
    WB_IDLE   = 1'b0,
    WB_STREAM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/result_writeback.sv
// Captures the four MMU results in one cycle and streams them to the host
// one byte per valid/ready beat, least significant byte of c00 first.
module result_writeback #(
  parameter int ACC_W   = tpu_pkg::ACC_W,
  parameter int NUM_RES = tpu_pkg::NUM_RES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture,
  input  logic signed [ACC_W-1:0] c00,
  input  logic signed [ACC_W-1:0] c01,
  input  logic signed [ACC_W-1:0] c10,
  input  logic signed [ACC_W-1:0] c11,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    host_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);
  import tpu_pkg::*;

  localparam int BYTES  = ACC_W / 8;
  localparam int NBEATS = NUM_RES * BYTES;
  localparam int BW     = $clog2(NBEATS);
  localparam int BUF_W  = NUM_RES * ACC_W;

  wb_state_e        state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [BW-1:0]    beat_nxt;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    beat_d      = beat_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    beat_nxt    = beat_q + 1'b1;

    case (state_q)
      WB_IDLE: begin
        if (capture) begin
          // c00 sits in the low bits so beat k is simply byte k of the buffer
          buf_d       = {c11, c10, c01, c00};
          beat_d      = '0;
          out_data_d  = c00[7:0];
          out_valid_d = 1'b1;
          state_d     = WB_STREAM;
        end
      end
      WB_STREAM: begin
        if (capture) overrun_d = 1'b1;
        if (host_ready) begin
          if (beat_q == BW'(NBEATS - 1)) begin
            beat_d      = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = WB_IDLE;
          end else begin
            beat_d     = beat_nxt;
            out_data_d = buf_q[{beat_nxt, 3'b000} +: 8];
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WB_IDLE;
      buf_q       <= '0;
      beat_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      beat_q      <= beat_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == WB_STREAM);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: a per-cycle vector table of inputs and
// hand-computed outputs, plus a reset sequence with random inputs.
module tb_result_writeback;
  localparam int ACC_W = 16;

  logic                    clk;
  logic                    rst;
  logic                    capture;
  logic signed [ACC_W-1:0] c00, c01, c10, c11;
  logic [7:0]              out_data;
  logic                    out_valid;
  logic                    host_ready;
  logic                    busy;
  logic                    done;
  logic                    overrun;

  result_writeback #(.ACC_W(ACC_W), .NUM_RES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .c00        (c00),
    .c01        (c01),
    .c10        (c10),
    .c11        (c11),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .host_ready (host_ready),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       cap;
    logic       sel;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       edone;
    logic       eovr;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  task automatic t(input logic r, input logic cap, input logic sel, input logic rdy,
                   input logic ev, input logic [7:0] ed, input logic edone,
                   input logic eovr);
    vec_t v;
    v.rst = r; v.cap = cap; v.sel = sel; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.edone = edone; v.eovr = eovr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d got=%02h want=%02h", name, idx, act, exp);
    end
  endtask

  task automatic set_data(input logic sel);
    if (sel) begin
      c00 = 16'hABCD; c01 = 16'h5566; c10 = 16'h7788; c11 = 16'h99AA;
    end else begin
      c00 = 16'h1234; c01 = 16'hFFFE; c10 = 16'h0001; c11 = 16'h8000;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; capture = 1'b0; host_ready = 1'b0;
    c00 = '0; c01 = '0; c10 = '0; c11 = '0;

    // Reset held three cycles with random inputs: every output stays zero
    for (int i = 0; i < 3; i++) begin
      capture    = 1'($urandom_range(0, 1));
      host_ready = 1'($urandom_range(0, 1));
      c00 = 16'($urandom); c01 = 16'($urandom);
      c10 = 16'($urandom); c11 = 16'($urandom);
      @(posedge clk); #1;
      check("rst_valid",   i, {7'd0, out_valid}, 8'h00);
      check("rst_data",    i, out_data,          8'h00);
      check("rst_busy",    i, {7'd0, busy},      8'h00);
      check("rst_done",    i, {7'd0, done},      8'h00);
      check("rst_overrun", i, {7'd0, overrun},   8'h00);
    end

    // Basic stream, ready held high
    t(0,1,0,1, 1,8'h34,0,0);
    t(0,0,0,1, 1,8'h12,0,0); t(0,0,0,1, 1,8'hFE,0,0);
    t(0,0,0,1, 1,8'hFF,0,0); t(0,0,0,1, 1,8'h01,0,0);
    t(0,0,0,1, 1,8'h00,0,0); t(0,0,0,1, 1,8'h00,0,0);
    t(0,0,0,1, 1,8'h80,0,0);
    t(0,0,0,1, 0,8'h00,1,0);
    t(0,0,0,1, 0,8'h00,0,0);

    // Backpressure, ready pattern 1,0,0,1 repeating
    t(0,1,0,0, 1,8'h34,0,0);
    t(0,0,0,1, 1,8'h12,0,0); t(0,0,0,0, 1,8'h12,0,0); t(0,0,0,0, 1,8'h12,0,0);
    t(0,0,0,1, 1,8'hFE,0,0); t(0,0,0,1, 1,8'hFF,0,0);
    t(0,0,0,0, 1,8'hFF,0,0); t(0,0,0,0, 1,8'hFF,0,0);
    t(0,0,0,1, 1,8'h01,0,0); t(0,0,0,1, 1,8'h00,0,0);
    t(0,0,0,0, 1,8'h00,0,0); t(0,0,0,0, 1,8'h00,0,0);
    t(0,0,0,1, 1,8'h00,0,0); t(0,0,0,1, 1,8'h80,0,0);
    t(0,0,0,0, 1,8'h80,0,0); t(0,0,0,0, 1,8'h80,0,0);
    t(0,0,0,1, 0,8'h00,1,0);
    t(0,0,0,0, 0,8'h00,0,0);

    // Overrun: second capture while beat 3 is presented
    t(0,1,0,1, 1,8'h34,0,0);
    t(0,0,0,1, 1,8'h12,0,0); t(0,0,0,1, 1,8'hFE,0,0); t(0,0,0,1, 1,8'hFF,0,0);
    t(0,1,1,1, 1,8'h01,0,1);
    t(0,0,0,1, 1,8'h00,0,1); t(0,0,0,1, 1,8'h00,0,1); t(0,0,0,1, 1,8'h80,0,1);
    t(0,0,0,1, 0,8'h00,1,1);
    t(0,0,0,1, 0,8'h00,0,1);
    t(1,0,0,1, 0,8'h00,0,0);

    // Back-to-back: capture on the done cycle, then capture on the final handshake
    t(0,1,0,1, 1,8'h34,0,0);
    t(0,0,0,1, 1,8'h12,0,0); t(0,0,0,1, 1,8'hFE,0,0); t(0,0,0,1, 1,8'hFF,0,0);
    t(0,0,0,1, 1,8'h01,0,0); t(0,0,0,1, 1,8'h00,0,0); t(0,0,0,1, 1,8'h00,0,0);
    t(0,0,0,1, 1,8'h80,0,0);
    t(0,0,0,1, 0,8'h00,1,0);
    t(0,1,1,1, 1,8'hCD,0,0);
    t(0,0,0,1, 1,8'hAB,0,0); t(0,0,0,1, 1,8'h66,0,0); t(0,0,0,1, 1,8'h55,0,0);
    t(0,0,0,1, 1,8'h88,0,0); t(0,0,0,1, 1,8'h77,0,0); t(0,0,0,1, 1,8'hAA,0,0);
    t(0,0,0,1, 1,8'h99,0,0);
    t(0,1,0,1, 0,8'h00,1,1);
    t(0,0,0,1, 0,8'h00,0,1);

    // Reset mid-stream at beat 5, with overrun set beforehand
    t(1,0,0,0, 0,8'h00,0,0);
    t(0,1,0,1, 1,8'h34,0,0);
    t(0,0,0,1, 1,8'h12,0,0); t(0,0,0,1, 1,8'hFE,0,0);
    t(0,1,1,1, 1,8'hFF,0,1);
    t(0,0,0,1, 1,8'h01,0,1); t(0,0,0,1, 1,8'h00,0,1);
    t(1,0,0,1, 0,8'h00,0,0);
    t(0,0,0,1, 0,8'h00,0,0);
    t(0,1,1,1, 1,8'hCD,0,0);
    t(0,0,0,1, 1,8'hAB,0,0); t(0,0,0,1, 1,8'h66,0,0); t(0,0,0,1, 1,8'h55,0,0);
    t(0,0,0,1, 1,8'h88,0,0); t(0,0,0,1, 1,8'h77,0,0); t(0,0,0,1, 1,8'hAA,0,0);
    t(0,0,0,1, 1,8'h99,0,0);
    t(0,0,0,1, 0,8'h00,1,0);
    t(0,0,0,0, 0,8'h00,0,0);

    foreach (vecs[i]) begin
      rst        = vecs[i].rst;
      capture    = vecs[i].cap;
      host_ready = vecs[i].rdy;
      set_data(vecs[i].sel);
      @(posedge clk); #1;
      check("valid",   i, {7'd0, out_valid}, {7'd0, vecs[i].ev});
      check("busy",    i, {7'd0, busy},      {7'd0, vecs[i].ev});
      check("done",    i, {7'd0, done},      {7'd0, vecs[i].edone});
      check("overrun", i, {7'd0, overrun},   {7'd0, vecs[i].eovr});
      if (vecs[i].ev || vecs[i].rst)
        check("data", i, out_data, vecs[i].ed);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/result_writeback.md
# result_writeback

Downstream stage of the control unit in the 2x2 TPU datapath. It captures the four accumulator results of the matrix-multiply unit (MMU) in one cycle, holds them in a local buffer, and streams them to the host one byte per beat over a valid/ready handshake. It reports completion and any dropped captures back to the control unit.

## Interface
Parameters:
- ACC_W, 16, width of each signed MMU result; must be a multiple of 8.
- NUM_RES, 4, number of results per operation (2x2 output matrix); fixed at 4.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- capture  in  1  one-cycle pulse from the control unit: the MMU results are valid this cycle.
- c00, c01, c10, c11  in  ACC_W each  signed MMU results, sampled only when capture=1 is accepted.
- out_data  out  8  byte presented to the host.
- out_valid  out  1  out_data holds a valid beat.
- host_ready  in  1  host accepts the beat this cycle.
- busy  out  1  buffer holds unsent data (state STREAM).
- done  out  1  one-cycle pulse after the final beat is accepted.
- overrun  out  1  sticky flag: a capture was dropped while busy.

## Operation
- States: IDLE, STREAM.
- IDLE: out_valid=0. When capture=1, latch c00,c01,c10,c11 into the buffer, clear the beat counter, and go to STREAM.
- STREAM: out_valid=1. out_data = byte[beat] of the buffer. Beat order: c00 LSB, c00 MSB, c01 LSB, c01 MSB, c10 LSB, c10 MSB, c11 LSB, c11 MSB. For general ACC_W there are ACC_W/8 bytes per result, least significant first, for 4*ACC_W/8 beats in total.
- A beat advances only on out_valid && host_ready. The beat counter is log2(4*ACC_W/8) bits.
- Final-beat handshake: go to IDLE and assert done=1 for exactly the next cycle.
- Bytes are raw two's-complement slices. There is no saturation, rounding or sign handling.
- Capture during STREAM is ignored: the buffer and counter are unchanged and overrun is set to 1. overrun clears only on rst.
- Capture in the cycle after the final handshake (IDLE, done=1) is accepted normally. done still pulses.
- Capture on the same cycle as the final handshake is in STREAM, so it is dropped and sets overrun.
- out_data and the buffer hold steady while out_valid=1 and host_ready=0.
- Reset values: state=IDLE, out_valid=0, out_data=0, busy=0, done=0, overrun=0, buffer=0, counter=0.
- Reset asserted mid-stream aborts the transfer. The next cycle shows the reset values and no done pulse.

## Timing
- Capture at edge N gives out_valid=1 with c00[7:0] from cycle N+1.
- With host_ready held high, one beat is sent per cycle. For ACC_W=16 the final beat is accepted at cycle N+8, done=1 in cycle N+9, and the block is ready for a new capture in cycle N+9.
- All outputs are registered. There is no combinational path from host_ready or capture to any output.
- busy = (state==STREAM).

## Structure
- The shared package tpu_pkg holds ACC_W, NUM_RES, the byte count per result, and the writeback state enum (WB_IDLE, WB_STREAM). The control unit imports the same constants.
- Single module, no sub-module. The byte selection is an indexed slice of the flattened 4*ACC_W buffer.

## Test plan
- Basic stream: capture with c00=0x1234, c01=0xFFFE, c10=0x0001, c11=0x8000, host_ready=1. Expect beats 34,12,FE,FF,01,00,00,80 on 8 consecutive cycles, then done for 1 cycle, then busy=0.
- Backpressure: the same data with host_ready toggling 1,0,0,1,... Expect each byte held stable while ready=0, no byte skipped or duplicated, and done only after the 8th accepted beat.
- Overrun: a second capture at beat 3 with different data. Expect the stream to still emit the original bytes, overrun=1 and sticky afterwards, and exactly one done.
- Back-to-back: a capture on the done cycle. Expect the new stream to start the next cycle and overrun to stay 0. A capture on the final-handshake cycle instead sets overrun.
- Reset mid-stream: rst at beat 5. Expect out_valid=0 the next cycle, no done, and overrun cleared. A subsequent capture streams correctly from beat 0.
- Reset values: hold rst for 3 cycles with random inputs. Expect all outputs 0 throughout.
